// File: rtl/slow_memory_arbiter.sv
// Round-robin arbiter giving NumReq requesters single-outstanding access to a slow memory; grant and response pass through combinationally (no added latency).
// Memory backpressure (mem_rready_i low) locks the chosen requester in HOLD; optional response watchdog enabled by SLOW_MEMORY_ARB_TIMEOUT_EN.
module slow_memory_arbiter #(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 10,
  parameter int TimeoutCycles = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq-1:0]         we_i,
  input  logic [NumReq*AddrWidth-1:0] addr_i,
  input  logic [NumReq*32-1:0]      wdata_i,
  input  logic [NumReq*4-1:0]       be_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [NumReq-1:0]         rvalid_o,
  output logic [31:0]               rdata_o,
  output logic [NumReq-1:0]         err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output logic [3:0]                mem_be_o,
  input  logic                      mem_rready_i,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      mem_rvalid_i
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2 || TimeoutCycles > 255) begin : g_param_check
    $error("slow_memory_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_RESP} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] winner;
  logic            winner_vld;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    if (int'(idx) == NumReq - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Scan upward from rr_ptr with wrap; first asserted request wins.
  always_comb begin
    int j;
    winner     = '0;
    winner_vld = 1'b0;
    j          = 0;
    for (int i = 0; i < NumReq; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NumReq) j = j - NumReq;
      if (!winner_vld && req_i[j]) begin
        winner_vld = 1'b1;
        winner     = IdxW'(j);
      end
    end
  end

`ifdef SLOW_MEMORY_ARB_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       wd_hit;

  assign wd_hit = (wd_q == 8'(TimeoutCycles - 1));

  // Held at zero outside WAIT_RESP, so every wait starts counting from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  wd_q <= '0;
    else if (state_q != WAIT_RESP) wd_q <= '0;
    else                          wd_q <= wd_q + 8'd1;
  end
`endif

  always_comb begin
    logic [IdxW-1:0] sel;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    gnt_o       = '0;
    rvalid_o    = '0;
    err_o       = '0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    sel         = (state_q == IDLE) ? winner : owner_q;

    // Outputs are forced quiet while reset is held, regardless of inputs.
    if (rst_ni) begin
      if ((state_q == IDLE && winner_vld) || state_q == HOLD) begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_i[sel];
        mem_addr_o  = addr_i[int'(sel)*AddrWidth +: AddrWidth];
        mem_wdata_o = wdata_i[int'(sel)*32 +: 32];
        mem_be_o    = be_i[int'(sel)*4 +: 4];
      end

      case (state_q)
        IDLE: begin
          if (winner_vld) begin
            owner_d = winner;
            if (mem_rready_i) begin
              gnt_o[winner] = 1'b1;
              rr_ptr_d      = next_idx(winner);
              state_d       = WAIT_RESP;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (mem_rready_i) begin
            gnt_o[owner_q] = 1'b1;
            rr_ptr_d       = next_idx(owner_q);
            state_d        = WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_rvalid_i) begin
            rvalid_o[owner_q] = 1'b1;
            rdata_o           = mem_rdata_i;
            state_d           = IDLE;
          end
`ifdef SLOW_MEMORY_ARB_TIMEOUT_EN
          else if (wd_hit) begin
            rvalid_o[owner_q] = 1'b1;
            err_o[owner_q]    = 1'b1;
            rdata_o           = 32'hBADC_AB1E;
            state_d           = IDLE;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

endmodule
